// File: rtl/regfile_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_pkg : shared types and constants for the register-file writeback path
// Rev 1.0
// ---------------------------------------------------------------------------
package regfile_pkg;

   localparam int DWIDTH = 8;
   localparam int RWIDTH = 3;

   localparam logic [RWIDTH-1:0] C_R0_ADDR = '0;

   typedef struct packed {
      logic              valid;
      logic [RWIDTH-1:0] addr;
      logic [DWIDTH-1:0] data;
   } wb_req_t;

   typedef enum logic {
      GNT_A = 1'b0,
      GNT_B = 1'b1
   } gnt_e;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arb2 : 2-way round-robin arbiter; req[0]=A, req[1]=B, gnt one-hot or zero
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_arb2
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   gnt_e r_rr_last;
   logic [1:0] w_gnt;

   // On a tie the side that did not win last time takes the grant.
   always_comb begin
      w_gnt    = 2'b00;
      w_gnt[0] = !reset && req[0] && (!req[1] || (r_rr_last == GNT_B));
      w_gnt[1] = !reset && req[1] && (!req[0] || (r_rr_last == GNT_A));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rr_last <= GNT_B;
      end else if (w_gnt[0]) begin
         r_rr_last <= GNT_A;
      end else if (w_gnt[1]) begin
         r_rr_last <= GNT_B;
      end
   end

   assign gnt = w_gnt;

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_wb_arbiter : shares the register-file write port between ALU and load
// Rev 1.0
// ---------------------------------------------------------------------------
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int DWIDTH = regfile_pkg::DWIDTH,
   parameter int RWIDTH = regfile_pkg::RWIDTH,
   parameter int CWIDTH = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_valid,
   input  logic [RWIDTH-1:0] a_addr,
   input  logic [DWIDTH-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [RWIDTH-1:0] b_addr,
   input  logic [DWIDTH-1:0] b_data,
   output logic              b_ready,
   output logic              we3,
   output logic [RWIDTH-1:0] wa3,
   output logic [DWIDTH-1:0] wd3,
   output logic [CWIDTH-1:0] wr_count
);

   localparam logic [CWIDTH-1:0] C_CNT_MAX = '1;

   logic [1:0]        w_gnt;
   wb_req_t           w_sel;
   logic              r_we3;
   logic [RWIDTH-1:0] r_wa3;
   logic [DWIDTH-1:0] r_wd3;
   logic [CWIDTH-1:0] r_wr_count;

   rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   ({b_valid, a_valid}),
      .gnt   (w_gnt)
   );

   always_comb begin
      w_sel = '0;
      if (w_gnt[0]) begin
         w_sel.valid = 1'b1;
         w_sel.addr  = a_addr;
         w_sel.data  = a_data;
      end else if (w_gnt[1]) begin
         w_sel.valid = 1'b1;
         w_sel.addr  = b_addr;
         w_sel.data  = b_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_we3 <= 1'b0;
         r_wa3 <= '0;
         r_wd3 <= '0;
      end else begin
         r_we3 <= w_sel.valid && (w_sel.addr != C_R0_ADDR);
         if (w_sel.valid) begin
            r_wa3 <= w_sel.addr;
            r_wd3 <= w_sel.data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_count <= '0;
      end else if (r_we3 && (r_wr_count != C_CNT_MAX)) begin
         r_wr_count <= r_wr_count + 1'b1;
      end
   end

   assign a_ready  = w_gnt[0];
   assign b_ready  = w_gnt[1];
   // A write already sitting in the output register is dropped while reset is held.
   assign we3      = r_we3 && !reset;
   assign wa3      = r_wa3;
   assign wd3      = r_wd3;
   assign wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter : scoreboard bench with a behavioural writeback model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

   localparam int CW      = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          a_valid, b_valid;
   logic [2:0]    a_addr, b_addr;
   logic [7:0]    a_data, b_data;
   logic          a_ready, b_ready;
   logic          we3;
   logic [2:0]    wa3;
   logic [7:0]    wd3;
   logic [CW-1:0] wr_count;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.DWIDTH(8), .RWIDTH(3), .CWIDTH(CW)) dut (
      .clk      (clk),
      .reset    (reset),
      .a_valid  (a_valid),
      .a_addr   (a_addr),
      .a_data   (a_data),
      .a_ready  (a_ready),
      .b_valid  (b_valid),
      .b_addr   (b_addr),
      .b_data   (b_data),
      .b_ready  (b_ready),
      .we3      (we3),
      .wa3      (wa3),
      .wd3      (wd3),
      .wr_count (wr_count)
   );

   typedef struct {
      int            cyc;
      logic          we;
      logic [2:0]    a;
      logic [7:0]    d;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   // Behavioural model state: last winner (1=A, 2=B), expected write of this cycle
   int         last = 2;
   logic       cur_we = 1'b0;
   logic [2:0] cur_a  = '0;
   logic [7:0] cur_d  = '0;
   int         cur_cnt = 0;
   logic [7:0] model_rf [8];
   logic [7:0] dut_rf   [8];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: compares the DUT write port against the queued expectation of this cycle.
   always @(negedge clk) begin
      #2;
      while (q.size() > 0 && q[0].cyc < cyc) begin
         exp_t s;
         s = q.pop_front();
         chk("stale_expectation", 32'(s.cyc), 32'(cyc));
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
         exp_t e;
         e = q.pop_front();
         chk("we3", 32'(we3), 32'(e.we));
         if (e.we) begin
            chk("wa3", 32'(wa3), 32'(e.a));
            chk("wd3", 32'(wd3), 32'(e.d));
         end
         chk("wr_count", 32'(wr_count), 32'(e.cnt));
      end
      if (we3 === 1'b1) dut_rf[wa3] = wd3;
   end

   task automatic step(input logic rst,
                       input logic av, input logic [2:0] aa, input logic [7:0] ad,
                       input logic bv, input logic [2:0] ba, input logic [7:0] bd,
                       output int g);
      exp_t       e;
      logic       n_we;
      logic [2:0] s_a;
      logic [7:0] s_d;
      int         n_cnt;
      @(negedge clk);
      reset = rst; a_valid = av; a_addr = aa; a_data = ad;
      b_valid = bv; b_addr = ba; b_data = bd;
      #1;
      if (rst)           g = 0;
      else if (av && bv) g = (last == 2) ? 1 : 2;
      else if (av)       g = 1;
      else if (bv)       g = 2;
      else               g = 0;
      chk("a_ready", 32'(a_ready), 32'(g == 1));
      chk("b_ready", 32'(b_ready), 32'(g == 2));
      if (rst && q.size() > 0 && q[$].cyc == cyc) begin
         e = q.pop_back();
         e.we = 1'b0;
         q.push_back(e);
      end
      if (!rst && cur_we) model_rf[cur_a] = cur_d;
      s_a  = (g == 1) ? aa : bb_sel(g, ba, cur_a);
      s_d  = (g == 1) ? ad : ((g == 2) ? bd : cur_d);
      n_we = !rst && (g != 0) && (s_a != 3'd0);
      if (rst)                            n_cnt = 0;
      else if (cur_we && cur_cnt < CNT_MAX) n_cnt = cur_cnt + 1;
      else                                n_cnt = cur_cnt;
      e.cyc = cyc + 1; e.we = n_we; e.a = s_a; e.d = s_d; e.cnt = CW'(n_cnt);
      q.push_back(e);
      cur_we = n_we; cur_a = s_a; cur_d = s_d; cur_cnt = n_cnt;
      if (rst)         last = 2;
      else if (g != 0) last = g;
   endtask

   function automatic logic [2:0] bb_sel(input int g, input logic [2:0] ba, input logic [2:0] hold);
      return (g == 2) ? ba : hold;
   endfunction

   task automatic idle(input int n);
      int g;
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, g);
   endtask

   initial begin
      int         g;
      logic [7:0] ad, bd;
      logic       pa, pb;
      logic [2:0] ra, rb;
      logic [7:0] rda, rdb;
      for (int i = 0; i < 8; i++) begin model_rf[i] = '0; dut_rf[i] = '0; end
      reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
      a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
      @(posedge clk);

      // Reset held two cycles with both requesters valid
      step(1'b1, 1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, g);
      step(1'b1, 1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, g);

      // Single requester
      step(1'b0, 1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00, g);
      idle(2);

      // Contention: requesters keep presenting fresh data after each grant
      step(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, g);
      ad = 8'h11; bd = 8'h22;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 3'd1, ad, 1'b1, 3'd2, bd, g);
         if (g == 1) ad = ad + 8'h01;
         if (g == 2) bd = bd + 8'h01;
      end
      idle(2);

      // Same address from both sides right after reset
      step(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, g);
      step(1'b0, 1'b1, 3'd4, 8'hAA, 1'b1, 3'd4, 8'hBB, g);
      step(1'b0, 1'b0, 3'd4, 8'hAA, 1'b1, 3'd4, 8'hBB, g);
      idle(3);
      chk("r4_final", 32'(dut_rf[4]), 32'h0000_00BB);

      // R0 filter, then a tie which must go to A
      step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'hFF, g);
      idle(1);
      step(1'b0, 1'b1, 3'd5, 8'h31, 1'b1, 3'd6, 8'h32, g);
      step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h32, g);
      idle(3);
      chk("r0_reads_zero", 32'(dut_rf[0]), 32'h0);

      // Reset one cycle after a grant discards the pending write
      step(1'b0, 1'b1, 3'd7, 8'h77, 1'b0, 3'd0, 8'h00, g);
      step(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, g);
      idle(1);
      step(1'b0, 1'b1, 3'd1, 8'hC1, 1'b1, 3'd2, 8'hC2, g);
      step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'hC2, g);
      idle(2);

      // Randomized traffic; requesters hold their write until accepted
      pa = 1'b0; pb = 1'b0; ra = '0; rb = '0; rda = '0; rdb = '0;
      for (int i = 0; i < 600; i++) begin
         if (!pa && $urandom_range(0, 3) != 0) begin
            pa = 1'b1; ra = 3'($urandom_range(0, 7)); rda = 8'($urandom);
         end
         if (!pb && $urandom_range(0, 3) != 0) begin
            pb = 1'b1; rb = 3'($urandom_range(0, 7)); rdb = 8'($urandom);
         end
         step(($urandom_range(0, 79) == 0), pa, ra, rda, pb, rb, rdb, g);
         if (g == 1) pa = 1'b0;
         if (g == 2) pb = 1'b0;
      end
      idle(3);
      @(negedge clk);
      #3;
      chk("queue_drained", 32'(q.size()), 32'd0);
      for (int i = 0; i < 8; i++) chk("regfile_contents", 32'(dut_rf[i]), 32'(model_rf[i]));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
